// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiply datapath stages.
// Operand width is fixed; the accumulator width is a per-instance parameter.
package mm_pkg;

  localparam int OPND_W     = 4;
  localparam int PROD_W     = 2 * OPND_W;
  localparam int MUL_CYCLES = 4;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // 4-bit adder slice shared by every shift-add step; bit OPND_W is the carry.
  function automatic logic [OPND_W:0] slice_add(input logic [OPND_W-1:0] x,
                                                input logic [OPND_W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

endpackage

// File: rtl/dot_product_mac4_if.sv
// Operand-in / result-out handshake bundle for dot_product_mac4.
// master = operand source and result sink, slave = the MAC stage.
interface dot_product_mac4_if #(
  parameter int ACC_W = 12
);
  import mm_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OPND_W-1:0] in_a;
  logic [OPND_W-1:0] in_b;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/shift_add_mul4.sv
// 4x4 unsigned multiplier, one shift-add step per clock on a 4-bit adder slice.
// o_done strobes during the last step; o_prod is exact on the following cycle.
module shift_add_mul4
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [OPND_W-1:0] i_a,
  input  logic [OPND_W-1:0] i_b,
  output logic              o_done,
  output logic [PROD_W-1:0] o_prod
);

  logic [OPND_W-1:0] r_a;
  logic [OPND_W-1:0] r_hi;
  logic [OPND_W-1:0] r_lo;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic [OPND_W:0]   w_sum;

  assign w_sum = slice_add(r_hi, r_lo[0] ? r_a : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_a    <= i_a;
      r_hi   <= '0;
      r_lo   <= i_b;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      // Carry lands in hi[3]; the consumed multiplier bit shifts out of lo.
      {r_hi, r_lo} <= {w_sum, r_lo[OPND_W-1:1]};
      r_cnt        <= r_cnt + 1'b1;
      if (r_cnt == CNT_W'(MUL_CYCLES - 1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_done = r_busy && (r_cnt == CNT_W'(MUL_CYCLES - 1));
  assign o_prod = {r_hi, r_lo};

endmodule

// File: rtl/dot_product_mac4.sv
// Sequential multiply-accumulate stage: accumulates 4-bit operand products
// until a last-flagged pair, then offers the dot product downstream.
module dot_product_mac4
  import mm_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  dot_product_mac4_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready;
  logic              r_last;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;
  logic              r_out_valid;
  logic [ACC_W-1:0]  r_out_data;
  logic              r_out_ovf;

  logic              w_accept;
  logic              w_out_fire;
  logic              w_mul_done;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W:0]    w_acc_wide;
  logic [ACC_W-1:0]  w_acc_sum;
  logic              w_carry;

  // in_ready is registered and only ever high in IDLE.
  assign w_accept   = r_in_ready & bus.in_valid;
  assign w_out_fire = r_out_valid & bus.out_ready;

  shift_add_mul4 u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_accept),
    .i_a     (bus.in_a),
    .i_b     (bus.in_b),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  assign w_acc_wide = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, w_prod};
  assign w_acc_sum  = w_acc_wide[ACC_W-1:0];
  assign w_carry    = w_acc_wide[ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_state_nxt = MUL;
      MUL:     if (w_mul_done) w_state_nxt = ACC;
      ACC:     w_state_nxt = r_last ? OUT : IDLE;
      OUT:     if (w_out_fire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_last      <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == IDLE);
      if (w_accept) begin
        r_last <= bus.in_last;
      end
      if (r_state == ACC) begin
        r_acc <= w_acc_sum;
        r_ovf <= r_ovf | w_carry;
        if (r_last) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_acc_sum;
          r_out_ovf   <= r_ovf | w_carry;
        end
      end
      if (r_state == OUT && w_out_fire) begin
        r_acc       <= '0;
        r_ovf       <= 1'b0;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_dot_product_mac4.sv
// Directed and seeded-random checks of dot_product_mac4 with ACC_W=12.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_dot_product_mac4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  dot_product_mac4_if #(.ACC_W(12)) bus ();

  dot_product_mac4 #(.ACC_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input logic last);
    int t;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [11:0] exp_d, input logic exp_o);
    int t;
    bus.out_ready = 1'b1;
    t = 0;
    while (!bus.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_data"},  32'(bus.out_data),  32'(exp_d));
    check({tag, "_ovf"},   32'(bus.out_ovf),   32'(exp_o));
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic rdy_seen;
    int total;
    int npairs;
    logic [3:0] ra, rb;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data),  32'd0);
    check("rst_out_ovf",  32'(bus.out_ovf),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 32'(bus.in_ready), 32'd1);

    // (3,5)+(15,15)+(2,7) = 254; result visible in the 6th cycle after the last accept
    send_pair(4'd3, 4'd5, 1'b0);
    send_pair(4'd15, 4'd15, 1'b0);
    send_pair(4'd2, 4'd7, 1'b1);
    n = 1;
    rdy_seen = bus.in_ready;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
      if (!bus.out_valid) rdy_seen = rdy_seen | bus.in_ready;
    end
    check("out_latency", 32'(n), 32'd6);
    check("rdy_low_busy", 32'(rdy_seen), 32'd0);
    recv("dot3", 12'd254, 1'b0);

    // Single-pair dot products, including a zero operand
    send_pair(4'd0, 4'd9, 1'b1);
    recv("zero", 12'd0, 1'b0);
    send_pair(4'd15, 4'd15, 1'b1);
    recv("max1", 12'd225, 1'b0);

    // 19 x 225 = 4275 wraps to 179 and sets the sticky overflow
    for (int i = 0; i < 18; i++) send_pair(4'd15, 4'd15, 1'b0);
    send_pair(4'd15, 4'd15, 1'b1);
    recv("wrap", 12'd179, 1'b1);
    send_pair(4'd1, 4'd1, 1'b1);
    recv("ovf_clr", 12'd1, 1'b0);

    // Backpressure: result held, in_valid pulses ignored
    send_pair(4'd4, 4'd4, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.in_a = 4'd15;
    bus.in_b = 4'd15;
    bus.in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_data",  32'(bus.out_data),  32'd16);
      check("bp_ready", 32'(bus.in_ready),  32'd0);
      bus.in_valid = i[0];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    recv("bp", 12'd16, 1'b0);
    check("bp_idle_rdy", 32'(bus.in_ready), 32'd1);
    send_pair(4'd1, 4'd1, 1'b1);
    recv("bp_after", 12'd1, 1'b0);

    // Reset during the second MUL cycle of (7,9)
    send_pair(4'd2, 4'd5, 1'b1);
    recv("pre_rst", 12'd10, 1'b0);
    send_pair(4'd7, 4'd9, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.in_ready),  32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data",  32'(bus.out_data),  32'd0);
    check("mid_rst_ovf",   32'(bus.out_ovf),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rdy_up", 32'(bus.in_ready), 32'd1);
    send_pair(4'd2, 4'd3, 1'b1);
    recv("post_rst", 12'd6, 1'b0);

    // Seeded random streams against a sum-of-products model
    for (int s = 0; s < 12; s++) begin
      npairs = int'($urandom_range(20, 1));
      total = 0;
      for (int p = 0; p < npairs; p++) begin
        repeat ($urandom_range(3, 0)) @(negedge clk);
        ra = 4'($urandom_range(15, 0));
        rb = 4'($urandom_range(15, 0));
        total += int'(ra) * int'(rb);
        send_pair(ra, rb, p == npairs - 1);
      end
      repeat ($urandom_range(5, 0)) @(negedge clk);
      recv("rand", total[11:0], total >= 4096);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dot_product_mac4.md
Name: dot_product_mac4

Overview:
- Sequential multiply-accumulate stage for the matrix-multiplication datapath.
- Consumes a stream of 4-bit unsigned operand pairs (one row element, one column element).
- Forms each 8-bit product by shift-and-add on a 4-bit adder slice, then accumulates products until a last-flagged pair arrives.
- Emits one dot-product result per row/column pair over a valid/ready handshake to the result-writeback stage.

Parameters:
- ACC_W, 12, accumulator/result width in bits; legal range 8..32.
- Operand width is fixed at 4 and is not a parameter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair
- in_a  in  4  row element, unsigned
- in_b  in  4  column element, unsigned
- in_last  in  1  final pair of the current dot product
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_W  accumulated dot product, modulo 2^ACC_W
- out_ovf  out  1  sticky: accumulation overflowed ACC_W during this dot product

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high; ports named clk and rst.
  - While rst is asserted: state=IDLE, acc=0, ovf=0, product regs=0, cnt=0, in_ready=0, out_valid=0, out_data=0, out_ovf=0.
  - in_ready rises on the first clk edge after rst deasserts.
  - Reset asserted mid-operation discards any partial product and accumulation. No result is emitted.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, capture a=in_a, b=in_b, last=in_last.
  - Clear hi=0, lo=b, cnt=0. Go to MUL.
- MUL (exactly 4 cycles, cnt 0..3):
  - Each cycle: {c,sum} = hi + (lo[0] ? a : 0), computed on the 4-bit adder slice.
  - Then {hi,lo} <= {c,sum,lo[3:1]}.
  - After cnt=3, product P={hi,lo} (8 bits) is exact. Go to ACC.
- ACC (1 cycle):
  - acc <= acc + zero-extend(P), modulo 2^ACC_W.
  - If the add carries out of bit ACC_W-1, ovf <= 1 (sticky).
  - If last, go to OUT; else go to IDLE.
- OUT:
  - out_valid=1, out_data=acc, out_ovf=ovf.
  - in_ready=0.
  - out_data and out_ovf are held stable while out_ready=0.
  - On out_valid & out_ready: acc<=0, ovf<=0, go to IDLE. out_valid drops the next cycle.
- Timing:
  - Pair accepted at edge T: MUL occupies T+1..T+4, ACC at T+5.
  - For a last pair, out_valid is asserted from T+6.
  - Throughput is one pair per 6 cycles; in_ready is 0 outside IDLE.
- Registered outputs: in_ready is decoded from registered state only, with no combinational path from in_valid. out_* are registered.
- Boundary conditions:
  - Zero operand: P=0, no special casing.
  - Single-pair dot product (in_last on the first pair) is legal.
  - in_valid with in_ready=0 is ignored; the source must hold its data.
  - out_ready high while out_valid=0 has no effect.
  - Accumulator wraps modulo 2^ACC_W; out_ovf flags the wrap.

Decomposition:
- Shared package (mm_pkg):
  - OPND_W=4, PROD_W=8
  - state enum {IDLE, MUL, ACC, OUT}
  - MUL_CYCLES=4
- One natural sub-module: shift_add_mul4. It holds the 4-cycle shift-add datapath (hi/lo/cnt registers around the 4-bit adder slice) with start/done strobes.
- dot_product_mac4 holds the FSM, accumulator and handshakes.

Test Plan:
- Reset release, then pairs (3,5), (15,15), (2,7,last), out_ready=1 -> out_data=254, out_ovf=0, out_valid 6 cycles after the last accept, in_ready low during MUL/ACC.
- Single pair (0,9,last) -> out_data=0. Single pair (15,15,last) -> out_data=225.
- ACC_W=12, 19 pairs of (15,15) with the last flagged -> out_data=179 (4275 mod 4096), out_ovf=1. The next dot product (1,1,last) -> out_data=1, out_ovf=0 (sticky cleared).
- Backpressure: result (4,4,last)=16 with out_ready=0 for 10 cycles -> out_valid held, out_data stable at 16, in_ready=0, in_valid pulses ignored. out_ready=1 -> one transfer, then IDLE.
- Reset mid-operation: assert rst during MUL cycle 2 of pair (7,9) -> all outputs 0 immediately. After release, (2,3,last) -> out_data=6 (no residue from the aborted pair).
- Randomized streams (1..20 pairs, random in_valid/out_ready gaps) against a reference model: sum of products mod 2^ACC_W and the overflow flag match.
